// File: rtl/victim_cache_ctrl.sv
// Victim cache tag-store sequencer: serialises probe and insert requests into
// tag_store command strobes and raises a writeback handshake for dirty victims.
module victim_cache_ctrl #(
    parameter int TAG_WIDTH = 4,
    parameter int NUM_WAYS  = 4,
    localparam int WW       = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic                 req_dirty,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [WW-1:0]        rsp_way,
    output logic                 rsp_dirty,
    output logic                 wb_valid,
    input  logic                 wb_ready,
    output logic [TAG_WIDTH-1:0] wb_tag,
    output logic [WW-1:0]        wb_way,
    output logic                 ts_write_en,
    output logic                 ts_read_en,
    output logic                 ts_lookup_en,
    output logic                 ts_valid_clear,
    output logic                 ts_dirty_set,
    output logic                 ts_dirty_clear,
    output logic [TAG_WIDTH-1:0] ts_tag_in,
    output logic [WW-1:0]        ts_way_index,
    input  logic                 ts_hit,
    input  logic [WW-1:0]        ts_hit_way_index,
    input  logic                 ts_valid_read,
    input  logic                 ts_dirty_read,
    input  logic [TAG_WIDTH-1:0] ts_tag_read,
    output logic [3:0]           dbg_state
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LOOKUP  = 4'd1;
    localparam logic [3:0] S_LK_WAIT = 4'd2;
    localparam logic [3:0] S_RD      = 4'd3;
    localparam logic [3:0] S_RD_WAIT = 4'd4;
    localparam logic [3:0] S_INVAL   = 4'd5;
    localparam logic [3:0] S_WB      = 4'd6;
    localparam logic [3:0] S_WRITE   = 4'd7;
    localparam logic [3:0] S_DIRTY   = 4'd8;
    localparam logic [3:0] S_RESP    = 4'd9;

    logic [3:0]           state;
    logic                 op_q;
    logic [TAG_WIDTH-1:0] tag_q;
    logic                 dirty_q;
    logic [WW-1:0]        way_q;
    logic                 hit_q;
    logic                 rsp_dirty_q;
    logic [TAG_WIDTH-1:0] wb_tag_q;
    logic [NUM_WAYS-1:0]  valid_q;
    logic [WW-1:0]        rr_ptr;
    logic                 free_found;
    logic [WW-1:0]        free_way;

    // Descending scan so the lowest-index invalid way is the one left standing.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_way   = WW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op_q        <= 1'b0;
            tag_q       <= '0;
            dirty_q     <= 1'b0;
            way_q       <= '0;
            hit_q       <= 1'b0;
            rsp_dirty_q <= 1'b0;
            wb_tag_q    <= '0;
            valid_q     <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q        <= req_op;
                        tag_q       <= req_tag;
                        dirty_q     <= req_dirty;
                        hit_q       <= 1'b0;
                        rsp_dirty_q <= 1'b0;
                        way_q       <= '0;
                        if (!req_op) begin
                            state <= S_LOOKUP;
                        end else if (free_found) begin
                            way_q <= free_way;
                            state <= S_WRITE;
                        end else begin
                            way_q  <= rr_ptr;
                            rr_ptr <= rr_ptr + WW'(1);
                            state  <= S_RD;
                        end
                    end
                end
                S_LOOKUP:  state <= S_LK_WAIT;
                S_LK_WAIT: begin
                    if (ts_hit) begin
                        way_q <= ts_hit_way_index;
                        hit_q <= 1'b1;
                        state <= S_RD;
                    end else begin
                        state <= S_RESP;
                    end
                end
                S_RD:      state <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (!op_q) begin
                        rsp_dirty_q <= ts_dirty_read;
                        state       <= S_INVAL;
                    end else if (ts_valid_read && ts_dirty_read) begin
                        wb_tag_q <= ts_tag_read;
                        state    <= S_WB;
                    end else begin
                        state <= S_WRITE;
                    end
                end
                S_INVAL: begin
                    valid_q[way_q] <= 1'b0;
                    state          <= S_RESP;
                end
                // wb_valid/wb_tag/wb_way hold until the cycle wb_ready is seen high.
                S_WB: begin
                    if (wb_ready) state <= S_WRITE;
                end
                S_WRITE: begin
                    valid_q[way_q] <= 1'b1;
                    state          <= S_DIRTY;
                end
                S_DIRTY:  state <= S_RESP;
                S_RESP:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    assign req_ready      = (state == S_IDLE) && !rst;
    assign rsp_valid      = (state == S_RESP);
    assign rsp_hit        = rsp_valid && hit_q;
    assign rsp_way        = rsp_valid ? way_q : '0;
    assign rsp_dirty      = rsp_valid && rsp_dirty_q;
    assign wb_valid       = (state == S_WB);
    assign wb_tag         = wb_valid ? wb_tag_q : '0;
    assign wb_way         = wb_valid ? way_q : '0;
    assign ts_lookup_en   = (state == S_LOOKUP);
    assign ts_read_en     = (state == S_RD);
    assign ts_valid_clear = (state == S_INVAL);
    assign ts_write_en    = (state == S_WRITE);
    assign ts_dirty_set   = (state == S_DIRTY) && dirty_q;
    assign ts_dirty_clear = (state == S_DIRTY) && !dirty_q;
    assign ts_tag_in      = (ts_lookup_en || ts_write_en) ? tag_q : '0;
    assign ts_way_index   = (ts_read_en || ts_valid_clear || ts_write_en || (state == S_DIRTY))
                            ? way_q : '0;
    assign dbg_state      = state;

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl with a behavioural tag_store model and
// a response scoreboard checking fields and acceptance-to-response latency.
module tb_victim_cache_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_op, req_dirty;
    logic [3:0] req_tag;
    logic       rsp_valid, rsp_hit, rsp_dirty;
    logic [1:0] rsp_way;
    logic       wb_valid, wb_ready;
    logic [3:0] wb_tag;
    logic [1:0] wb_way;
    logic       ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear, ts_dirty_set, ts_dirty_clear;
    logic [3:0] ts_tag_in;
    logic [1:0] ts_way_index;
    logic       ts_hit;
    logic [1:0] ts_hit_way_index;
    logic       ts_valid_read, ts_dirty_read;
    logic [3:0] ts_tag_read;
    logic [3:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [11:0] exp_q[$];

    logic [3:0] m_tag [0:3];
    logic [3:0] m_valid, m_dirty;

    always #5 clk = ~clk;

    victim_cache_ctrl #(.TAG_WIDTH(4), .NUM_WAYS(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_tag(req_tag), .req_dirty(req_dirty),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_dirty(rsp_dirty),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag), .wb_way(wb_way),
        .ts_write_en(ts_write_en), .ts_read_en(ts_read_en), .ts_lookup_en(ts_lookup_en),
        .ts_valid_clear(ts_valid_clear), .ts_dirty_set(ts_dirty_set), .ts_dirty_clear(ts_dirty_clear),
        .ts_tag_in(ts_tag_in), .ts_way_index(ts_way_index),
        .ts_hit(ts_hit), .ts_hit_way_index(ts_hit_way_index),
        .ts_valid_read(ts_valid_read), .ts_dirty_read(ts_dirty_read), .ts_tag_read(ts_tag_read),
        .dbg_state(dbg_state)
    );

    // Tag store model: results registered on the command edge, held until the next command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_hit           <= 1'b0;
            ts_hit_way_index <= '0;
            ts_valid_read    <= 1'b0;
            ts_dirty_read    <= 1'b0;
            ts_tag_read      <= '0;
            m_valid          <= '0;
            m_dirty          <= '0;
            for (int i = 0; i < 4; i++) m_tag[i] <= '0;
        end else begin
            if (ts_lookup_en) begin
                ts_hit           <= 1'b0;
                ts_hit_way_index <= '0;
                for (int i = 3; i >= 0; i--) begin
                    if (m_valid[i] && m_tag[i] == ts_tag_in) begin
                        ts_hit           <= 1'b1;
                        ts_hit_way_index <= 2'(i);
                    end
                end
            end
            if (ts_read_en) begin
                ts_valid_read <= m_valid[ts_way_index];
                ts_dirty_read <= m_dirty[ts_way_index];
                ts_tag_read   <= m_tag[ts_way_index];
            end
            if (ts_write_en) begin
                m_tag[ts_way_index]   <= ts_tag_in;
                m_valid[ts_way_index] <= 1'b1;
            end
            if (ts_valid_clear) m_valid[ts_way_index] <= 1'b0;
            if (ts_dirty_set)   m_dirty[ts_way_index] <= 1'b1;
            if (ts_dirty_clear) m_dirty[ts_way_index] <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_strobes_idle();
        check("strobes_zero", {ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear,
                               ts_dirty_set, ts_dirty_clear}, 6'b0);
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_idle", req_ready, 1);
    endtask

    // One request, from acceptance to the cycle after its response.
    task automatic do_req(input logic op, input logic [3:0] tag, input logic dty,
                          input logic e_hit, input logic [1:0] e_way, input logic e_dirty,
                          input int e_lat, input int e_rd,
                          input logic e_wb, input logic [3:0] e_wb_tag, input int wb_stall);
        int lat = 1, rd_cnt = 0, clr_cnt = 0, stall_cnt = 0;
        logic hs_done = 1'b0, saw_wb = 1'b0, got = 1'b0;
        logic [11:0] e;
        wait_ready();
        exp_q.push_back({e_hit, e_way, e_dirty, 8'(e_lat)});
        req_valid = 1'b1;
        req_op    = op;
        req_tag   = tag;
        req_dirty = dty;
        wb_ready  = (wb_stall == 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 1'($urandom_range(0, 1));
        req_tag   = 4'($urandom_range(0, 15));
        req_dirty = 1'($urandom_range(0, 1));
        while (!got && lat < 40) begin
            check("one_strobe", ($countones({ts_write_en, ts_read_en, ts_lookup_en, ts_valid_clear,
                                             ts_dirty_set, ts_dirty_clear}) <= 1), 1);
            check("req_ready_busy", req_ready, 0);
            if (ts_read_en) rd_cnt++;
            if (ts_valid_clear) clr_cnt++;
            if (ts_write_en && e_wb) check("write_after_hs", hs_done, 1);
            if (wb_valid) begin
                saw_wb = 1'b1;
                check("wb_tag", wb_tag, e_wb_tag);
                check("wb_way", wb_way, e_way);
            end
            if (rsp_valid) begin
                got = 1'b1;
                e = exp_q.pop_front();
                check("rsp_hit", rsp_hit, e[11]);
                check("rsp_way", rsp_way, e[10:9]);
                check("rsp_dirty", rsp_dirty, e[8]);
                check("rsp_latency", lat, e[7:0]);
            end else begin
                wb_ready = (stall_cnt >= wb_stall);
                if (wb_valid && !wb_ready) stall_cnt++;
                if (wb_valid && wb_ready) hs_done = 1'b1;
                @(negedge clk);
                lat++;
            end
        end
        check("rsp_seen", got, 1);
        if (!got && exp_q.size() > 0) e = exp_q.pop_front();
        check("read_count", rd_cnt, e_rd);
        check("clear_count", clr_cnt, (!op && e_hit) ? 1 : 0);
        check("wb_seen", saw_wb, e_wb);
        wb_ready = 1'b0;
        @(negedge clk);
        check("rsp_pulse_end", rsp_valid, 0);
        check("req_ready_after", req_ready, 1);
    endtask

    initial begin
        int guard;
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_tag = '0; req_dirty = 1'b0; wb_ready = 1'b0;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_state", dbg_state, 0);
        check_strobes_idle();
        rst = 1'b0;
        #1 check("post_rst_ready", req_ready, 1);
        @(negedge clk);

        // Fill invalid ways in order.
        do_req(1, 4'hA, 0, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);
        do_req(1, 4'hB, 0, 0, 2'd1, 0, 3, 0, 0, 4'h0, 0);
        do_req(1, 4'hC, 0, 0, 2'd2, 0, 3, 0, 0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            check("ts_valid_after_ins", m_valid[i], 1);
            check("ts_dirty_after_ins", m_dirty[i], 0);
        end
        check("ts_tag_w1", m_tag[1], 4'hB);

        // Probe hit invalidates; second probe misses; never-inserted tag misses.
        do_req(0, 4'hB, 0, 1, 2'd1, 0, 6, 1, 0, 4'h0, 0);
        check("ts_valid_w1_cleared", m_valid[1], 0);
        do_req(0, 4'hB, 0, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);
        do_req(0, 4'hF, 0, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);

        // Refill way1 (lowest invalid) and way3.
        do_req(1, 4'h1, 0, 0, 2'd1, 0, 3, 0, 0, 4'h0, 0);
        do_req(1, 4'h3, 0, 0, 2'd3, 0, 3, 0, 0, 4'h0, 0);

        // All full: round-robin victims, clean ones need no writeback.
        do_req(1, 4'h5, 1, 0, 2'd0, 0, 5, 1, 0, 4'h0, 0);
        check("ts_dirty_w0_set", m_dirty[0], 1);
        do_req(1, 4'h6, 1, 0, 2'd1, 0, 5, 1, 0, 4'h0, 0);
        do_req(1, 4'h7, 1, 0, 2'd2, 0, 5, 1, 0, 4'h0, 0);
        do_req(1, 4'h8, 0, 0, 2'd3, 0, 5, 1, 0, 4'h0, 0);
        // Pointer wraps to way0, which now holds dirty tag 5; stall the writeback 3 cycles.
        do_req(1, 4'h9, 0, 0, 2'd0, 0, 9, 1, 1, 4'h5, 3);
        check("ts_tag_w0", m_tag[0], 4'h9);
        check("ts_dirty_w0_cleared", m_dirty[0], 0);
        // Dirty victim with wb_ready already high.
        do_req(1, 4'hB, 1, 0, 2'd1, 0, 6, 1, 1, 4'h6, 0);

        do_req(0, 4'h9, 0, 1, 2'd0, 0, 6, 1, 0, 4'h0, 0);
        do_req(0, 4'h5, 0, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);
        do_req(0, 4'hB, 0, 1, 2'd1, 1, 6, 1, 0, 4'h0, 0);

        do_req(1, 4'hD, 1, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);
        do_req(1, 4'hE, 1, 0, 2'd1, 0, 3, 0, 0, 4'h0, 0);

        // Reset while waiting in WB on dirty victim way2 (tag 7).
        wait_ready();
        req_valid = 1'b1; req_op = 1'b1; req_tag = 4'h1; req_dirty = 1'b1; wb_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (!wb_valid && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("wb_valid_pre_rst", wb_valid, 1);
        check("wb_tag_pre_rst", wb_tag, 4'h7);
        check("wb_way_pre_rst", wb_way, 2'd2);
        rst = 1'b1;
        #1;
        check("rst_wb_valid_drop", wb_valid, 0);
        check("rst_req_ready_drop", req_ready, 0);
        check("rst_rsp_valid_drop", rsp_valid, 0);
        check_strobes_idle();
        @(negedge clk);
        rst = 1'b0;
        #1 check("rel_req_ready", req_ready, 1);
        @(negedge clk);
        do_req(1, 4'h4, 0, 0, 2'd0, 0, 3, 0, 0, 4'h0, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
